// File: rtl/uart_pkg.sv
// Shared types and helpers for the flexible UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        COMMIT,
        BREAK_WAIT
    } state_t;

    // Synchroniser flops reset to the idle (mark) level of the line.
    localparam logic SYNC_RST_VAL = 1'b1;

    // Width of a counter that must reach n-1; at least one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous serial input.
// Synchronous active-low reset loads both flops with the line idle level.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Async,
    output logic o_Sync
);

    logic meta;

    // Two-stage resynchronisation of the raw line into the clock domain.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            meta   <= SYNC_RST_VAL;
            o_Sync <= SYNC_RST_VAL;
        end else begin
            meta   <= i_Async;
            o_Sync <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_flex.sv
// Parametrised UART receiver: 5-9 data bits, optional parity, 1 or 2 stop
// bits, break/overrun detection and a valid/ready holding register.
// Optional feature macro: UART_RX_FLEX_PARITY_EN (enables the parity bit and
// o_Parity_Err; when undefined the frame is start + data + stop).
module uart_rx_flex
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_RX_Serial,
    input  logic                 i_RX_Ready,
    output logic                 o_RX_Valid,
    output logic [DATA_BITS-1:0] o_RX_Data,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Break,
    output logic                 o_Overrun
);

    localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] IDX_DLAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_SLAST = IDX_W'(STOP_BITS - 1);

    logic rx_s;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par_q, par_n;
    logic                 ferr_acc, ferr_acc_n;
    logic                 stop0, stop0_n;

    logic                 valid_q, valid_n;
    logic [DATA_BITS-1:0] data_q, data_n;
    logic                 ferr_q, ferr_n;
    logic                 perr_q, perr_n;
    logic                 brk_q, brk_n;
    logic                 ovr_q, ovr_n;

    logic bit_tick;
    logic is_break;
    logic frame_perr;

    uart_rx_sync u_sync (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .i_Async (i_RX_Serial),
        .o_Sync  (rx_s)
    );

    assign bit_tick = (cnt == CNT_LAST);
    assign is_break = (shift == '0) && !par_q && !stop0;

`ifdef UART_RX_FLEX_PARITY_EN
    assign frame_perr = ((^shift) ^ par_q) != PARITY_ODD[0];
`else
    logic unused_par_odd;
    assign frame_perr     = 1'b0;
    assign unused_par_odd = ^PARITY_ODD;
`endif

    // Next-state, datapath and holding-register update for the receive FSM.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = idx;
        shift_n    = shift;
        par_n      = par_q;
        ferr_acc_n = ferr_acc;
        stop0_n    = stop0;
        valid_n    = valid_q;
        data_n     = data_q;
        ferr_n     = ferr_q;
        perr_n     = perr_q;
        brk_n      = brk_q;
        ovr_n      = 1'b0;

        if (valid_q && i_RX_Ready) begin
            valid_n = 1'b0;
        end

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n      = '0;
                    idx_n      = '0;
                    ferr_acc_n = 1'b0;
                    state_n    = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_n   = '0;
                    // Shift in from the MSB: after DATA_BITS samples the
                    // first bit on the line sits in bit 0.
                    shift_n = {rx_s, shift[DATA_BITS-1:1]};
                    if (idx == IDX_DLAST) begin
                        idx_n   = '0;
`ifdef UART_RX_FLEX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`ifdef UART_RX_FLEX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    cnt_n   = '0;
                    par_n   = rx_s;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        ferr_acc_n = 1'b1;
                    end
                    if (idx == '0) begin
                        stop0_n = rx_s;
                    end
                    if (idx == IDX_SLAST) begin
                        state_n = COMMIT;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            COMMIT: begin
                if (!valid_q || i_RX_Ready) begin
                    valid_n = 1'b1;
                    data_n  = shift;
                    ferr_n  = ferr_acc;
                    perr_n  = frame_perr;
                    brk_n   = is_break;
                end else begin
                    ovr_n = 1'b1;
                end
                state_n = is_break ? BREAK_WAIT : IDLE;
            end
            BREAK_WAIT: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            par_q    <= 1'b0;
            ferr_acc <= 1'b0;
            stop0    <= 1'b1;
            valid_q  <= 1'b0;
            data_q   <= '0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            brk_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shift    <= shift_n;
            par_q    <= par_n;
            ferr_acc <= ferr_acc_n;
            stop0    <= stop0_n;
            valid_q  <= valid_n;
            data_q   <= data_n;
            ferr_q   <= ferr_n;
            perr_q   <= perr_n;
            brk_q    <= brk_n;
            ovr_q    <= ovr_n;
        end
    end

    assign o_RX_Valid   = valid_q;
    assign o_RX_Data    = data_q;
    assign o_Frame_Err  = ferr_q;
    assign o_Parity_Err = perr_q;
    assign o_Break      = brk_q;
    assign o_Overrun    = ovr_q;

endmodule

// File: doc/uart_rx_flex.md
# uart_rx_flex

Parametrised serial receiver for the console/controller link: configurable frame format (5–9 data bits, optional parity, 1 or 2 stop bits) and a valid/ready output holding register. Sits between the board RX pin and game-input decode logic. Adds what the fixed 8N1 receiver lacks: input synchronisation, framing, parity, break and overrun detection, and back-pressure.

## Interface
- CLKS_PER_BIT, 217, clock cycles per bit; legal range 4–65535.
- DATA_BITS, 8, data bits per frame; legal range 5–9.
- STOP_BITS, 1, stop bits checked; legal values 1 or 2.
- PARITY_ODD, 0, 1 selects odd parity, 0 selects even parity. Used only when UART_RX_FLEX_PARITY_EN is defined.
- i_Clock  in  1  sole clock.
- i_Rst_n  in  1  reset, synchronous, active-low.
- i_RX_Serial  in  1  asynchronous serial line; idles high.
- i_RX_Ready  in  1  consumer accepts the held word.
- o_RX_Valid  out  1  holding register full.
- o_RX_Data  out  DATA_BITS  received word, LSB = first bit on the line.
- o_Frame_Err  out  1  held word had a bad stop bit.
- o_Parity_Err  out  1  held word failed the parity check.
- o_Break  out  1  held word is a break condition.
- o_Overrun  out  1  one-cycle pulse when a completed frame is dropped.

## Operation
- Reset (i_Rst_n low at a clock edge):
  - All outputs go to 0.
  - State goes to IDLE; counters clear.
  - Both synchroniser flops load 1.
  - Reset overrides any frame in flight; the partial frame is discarded.
- Input path: i_RX_Serial passes through a 2-flop synchroniser, giving signal rx_s. The FSM uses only rx_s.
- Bit counter width is $clog2(CLKS_PER_BIT). Bit index width is $clog2(DATA_BITS+1).
- States and transitions:
  - IDLE: if rx_s==0, go to START with the counter cleared.
  - START: count to (CLKS_PER_BIT-1)/2.
    - If rx_s==0 there, clear the counter and go to DATA.
    - Otherwise it was a glitch; go to IDLE.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[idx] and increment idx.
    - After DATA_BITS samples, go to PARITY if enabled, else STOP.
  - PARITY: after CLKS_PER_BIT cycles, sample the parity bit.
    - Error if XOR(data, parity bit) != PARITY_ODD.
  - STOP: sample each of the STOP_BITS stop bits at CLKS_PER_BIT intervals.
    - Any stop bit that is 0 sets the frame error.
    - After the final stop sample, go to COMMIT.
  - COMMIT: one cycle. Deliver the word (see below).
    - If the word is a break, go to BREAK_WAIT; otherwise go to IDLE.
  - BREAK_WAIT: stay until rx_s==1, then go to IDLE. A line held low never retriggers START.
- Break definition: all data bits 0, parity bit 0 (if present), and the first stop bit 0. A break sets o_Break and o_Frame_Err together.
- Delivery in COMMIT:
  - If the register is empty, or is being drained this cycle (o_RX_Valid & i_RX_Ready): load data and flags; o_RX_Valid stays or goes to 1.
  - Otherwise: keep the old word and pulse o_Overrun for one cycle.
- Handshake: a word transfers on any cycle with o_RX_Valid & i_RX_Ready.
  - Without a simultaneous load, o_RX_Valid drops the next cycle.
  - While o_RX_Valid is high, o_RX_Data and all flags are stable.
- Unused encodings of the state register go to IDLE.

## Timing
- Synchroniser latency: 2 cycles.
- Detection to START confirmation: (CLKS_PER_BIT-1)/2 + 1 cycles.
- Each bit is sampled CLKS_PER_BIT cycles after the previous sample, i.e. at mid-bit.
- o_RX_Valid rises 1 cycle after the final stop sample (the COMMIT register update).
- Frame to idle: the FSM reaches IDLE 1 cycle after COMMIT, i.e. before the second half of the last stop bit. Back-to-back frames are received without loss.
- o_Overrun is high for exactly one cycle per dropped frame.

## Configuration
- Macro UART_RX_FLEX_PARITY_EN.
  - Defined: the PARITY state is present and o_Parity_Err is live.
  - Undefined: PARITY is absent, the frame is start + data + stop, and o_Parity_Err is tied to 0.

## Structure
- Package uart_pkg holds:
  - the state typedef (IDLE, START, DATA, PARITY, STOP, COMMIT, BREAK_WAIT);
  - a function computing the counter width;
  - the synchroniser reset-value constant.
- Sub-module uart_rx_sync: the 2-flop synchroniser with synchronous active-low reset to 1. It is shared with the future TX loopback checker.

## Test plan
- 8N1, CLKS_PER_BIT=16, byte 0xA5, i_RX_Ready=1 → o_RX_Valid pulses once with o_RX_Data=0xA5 and all flags 0.
- Parity enabled (even), byte 0x03 sent with parity bit 1 → o_Parity_Err=1 and data 0x03. Repeat with parity bit 0 → no error.
- 0x5A sent with stop bit 0 → o_Frame_Err=1, o_Break=0.
- Line held low for 3 frame times → one word 0x00 with o_Break=1 and o_Frame_Err=1; no further words until the line has returned high and a new start bit arrives.
- i_RX_Ready=0; frames 0x11 then 0x22 → o_RX_Data stays 0x11 and o_Overrun pulses once. Raise i_RX_Ready in the cycle 0x33 commits → 0x11 is accepted, then 0x33 is presented, with no overrun.
- Low glitch of CLKS_PER_BIT/4 cycles → no word. i_Rst_n low mid-frame → all outputs 0; the next clean frame 0x7E is received correctly.
